// File: rtl/mux_nto1_rr_reg.sv
// Registered N-to-1 selector with valid/ready on every input and on the output,
// manual-select or round-robin grant. Define MUX_TRISTATE_EN to float y while disabled.
module mux_nto1_rr_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      dis,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [SELW-1:0]           ch_id
);

    // Handshake: a beat moves on any interface in a cycle where valid && ready are
    // both high at the rising edge; valid never waits on ready, ready may depend on valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    y_q, y_d;
    logic [SELW-1:0]     ch_q, ch_d;
    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                can_load;
    logic                gnt_vld;
    logic [SELW-1:0]     gnt_idx;
    logic [CHANNELS-1:0] gnt_onehot;
    int                  idx;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        can_load = !dis && ((state_q == EMPTY) || y_ready);
        if (can_load) begin
            if (!mode) begin
                if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = sel;
                end
            end else begin
                // Search starts just after the last channel served and wraps.
                for (int i = 1; i <= CHANNELS; i++) begin
                    idx = (int'(rr_ptr_q) + i) % CHANNELS;
                    if (!gnt_vld && in_valid[idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            gnt_onehot[k] = gnt_vld && (gnt_idx == SELW'(k));
        end
    end

    assign in_ready = rst ? '0 : gnt_onehot;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            // Covers both a load into EMPTY and a pop+load in the same cycle.
            state_d = FULL;
            y_d     = in_data[gnt_idx*WIDTH +: WIDTH];
            ch_d    = gnt_idx;
            if (mode) begin
                rr_ptr_d = gnt_idx;
            end
        end else if ((state_q == FULL) && y_ready && !dis) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            y_q      <= '0;
            ch_q     <= '0;
            rr_ptr_q <= SELW'(CHANNELS - 1);
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign y_valid = !dis && (state_q == FULL);
    assign ch_id   = ch_q;

`ifdef MUX_TRISTATE_EN
    assign y = dis ? {WIDTH{1'bz}} : y_q;
`else
    assign y = dis ? '0 : y_q;
`endif

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Directed bench for mux_nto1_rr_reg (WIDTH=4, CHANNELS=4): driver issues vectors and
// queues expected {ch_id, y}; a negedge monitor pops on every output handshake.
module tb_mux_nto1_rr_reg;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SELW     = 2;
  localparam int EW       = SELW + WIDTH;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      dis;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;
  logic                      y_ready;
  logic [SELW-1:0]           ch_id;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;
  logic [WIDTH-1:0] y_dis_exp;

  mux_nto1_rr_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .dis(dis), .y(y),
    .y_valid(y_valid), .y_ready(y_ready), .ch_id(ch_id)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_lane(input int k, input logic [WIDTH-1:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_out(input logic [SELW-1:0] ch, input logic [WIDTH-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch=%0d y=%h with nothing expected at %0t", ch_id, y, $time);
      end else begin
        check("sb_out", 16'({ch_id, y}), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
`ifdef MUX_TRISTATE_EN
    y_dis_exp = 4'bzzzz;
`else
    y_dis_exp = 4'b0000;
`endif
    rst = 1'b1; in_data = '0; in_valid = 4'b1111; sel = '0; mode = 1'b1;
    dis = 1'b0; y_ready = 1'b0;

    // reset state
    at_neg();
    check("rst_y", 16'(y), 16'h0);
    check("rst_y_valid", 16'(y_valid), 16'h0);
    check("rst_ch_id", 16'(ch_id), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h0);
    tick();
    rst = 1'b0; in_valid = '0;

    // 1. manual select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_lane(2, 4'hA);
    at_neg();
    check("t1_in_ready", 16'(in_ready), 16'h4);
    expect_out(2'd2, 4'hA);
    tick();
    in_valid = '0;
    at_neg();
    check("t1_y", 16'(y), 16'hA);
    check("t1_y_valid", 16'(y_valid), 16'h1);
    check("t1_ch_id", 16'(ch_id), 16'h2);
    check("t1_hold_in_ready", 16'(in_ready), 16'h0);
    tick();
    y_ready = 1'b1;
    at_neg();
    tick();

    // 2. round-robin fairness, one beat per cycle
    mode = 1'b1; in_valid = 4'b1111;
    set_lane(0, 4'h1); set_lane(1, 4'h2); set_lane(2, 4'h3); set_lane(3, 4'h4);
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("t2_in_ready", 16'(in_ready), 16'(4'b0001 << (i % 4)));
      expect_out(SELW'(i % 4), WIDTH'((i % 4) + 1));
      tick();
    end
    in_valid = '0;
    at_neg();
    tick();

    // 3. backpressure, then pop+load in the same cycle
    mode = 1'b0; sel = 2'd0; y_ready = 1'b0; in_valid = 4'b0001; set_lane(0, 4'h5);
    at_neg();
    check("t3_in_ready_load", 16'(in_ready), 16'h1);
    expect_out(2'd0, 4'h5);
    tick();
    set_lane(0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t3_hold_y", 16'(y), 16'h5);
      check("t3_hold_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    y_ready = 1'b1;
    expect_out(2'd0, 4'h6);
    at_neg();
    check("t3_popload_in_ready", 16'(in_ready), 16'h1);
    tick();
    in_valid = '0;
    at_neg();
    check("t3_y_next", 16'(y), 16'h6);
    tick();

    // 4. disable freezes and floats/zeroes y
    sel = 2'd1; y_ready = 1'b0; in_valid = 4'b0010; set_lane(1, 4'h9);
    at_neg();
    check("t4_in_ready_load", 16'(in_ready), 16'h2);
    expect_out(2'd1, 4'h9);
    tick();
    dis = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check("t4_dis_y", 16'(y), 16'(y_dis_exp));
      check("t4_dis_y_valid", 16'(y_valid), 16'h0);
      check("t4_dis_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    dis = 1'b0; in_valid = '0; y_ready = 1'b0;
    at_neg();
    check("t4_en_y", 16'(y), 16'h9);
    check("t4_en_y_valid", 16'(y_valid), 16'h1);
    check("t4_en_ch_id", 16'(ch_id), 16'h1);
    tick();
    y_ready = 1'b1;
    at_neg();
    tick();

    // 5. asynchronous reset while FULL
    mode = 1'b1; y_ready = 1'b0; in_valid = 4'b0100; set_lane(2, 4'h7);
    at_neg();
    check("t5_in_ready_load", 16'(in_ready), 16'h4);
    expect_out(2'd2, 4'h7);
    tick();
    in_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_y", 16'(y), 16'h0);
    check("t5_async_y_valid", 16'(y_valid), 16'h0);
    check("t5_async_ch_id", 16'(ch_id), 16'h0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    at_neg();
    check("t5_post_rst_y_valid", 16'(y_valid), 16'h0);
    tick();
    y_ready = 1'b1; in_valid = 4'b1010; set_lane(1, 4'hB); set_lane(3, 4'hC);
    at_neg();
    check("t5_rr_first", 16'(in_ready), 16'h2);
    expect_out(2'd1, 4'hB);
    tick();
    in_valid = '0;
    at_neg();
    tick();

    // 6. skip empty channels / invalid manual select
    in_valid = 4'b0001; set_lane(0, 4'hD);
    at_neg();
    check("t6_rr_wrap", 16'(in_ready), 16'h1);
    expect_out(2'd0, 4'hD);
    tick();
    in_valid = '0;
    at_neg();
    tick();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
    at_neg();
    check("t6_sel_no_grant", 16'(in_ready), 16'h0);
    tick();
    in_valid = '0;
    at_neg();
    check("t6_y_valid", 16'(y_valid), 16'h0);
    tick();

    tick();
    check("sb_drain", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
